// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes and initiator state encoding
package axil_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WB,
      RA,
      RD,
      DONE
   } axil_state_t;

endpackage

// File: rtl/axilite_master.sv
// rtl/axilite_master.sv - AXI4-Lite initiator, one outstanding read or write per command
module axilite_master
   import axil_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_wr,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   input  logic [DATA_W/8-1:0]   cmd_wstrb,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [ADDR_W-1:0]     m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_W-1:0]     m_axi_wdata,
   output logic [DATA_W/8-1:0]   m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_W-1:0]     m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_W-1:0]     m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam int STRB_W = DATA_W / 8;

   axil_state_t         r_state;
   axil_state_t         w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic [DATA_W-1:0]   r_rsp_rdata;
   logic [1:0]          r_rsp_resp;
   logic                r_awvalid;
   logic                r_wvalid;

   logic                w_accept;
   logic                w_aw_hs;
   logic                w_w_hs;
   logic                w_aw_done;
   logic                w_w_done;
   logic                w_b_hs;
   logic                w_r_hs;

   assign w_accept  = cmd_valid && (r_state == IDLE);
   assign w_aw_hs   = r_awvalid && m_axi_awready;
   assign w_w_hs    = r_wvalid && m_axi_wready;
   // A channel counts as done once its valid has dropped or is being taken this cycle.
   assign w_aw_done = !r_awvalid || m_axi_awready;
   assign w_w_done  = !r_wvalid || m_axi_wready;
   assign w_b_hs    = (r_state == WB) && m_axi_bvalid;
   assign w_r_hs    = (r_state == RD) && m_axi_rvalid;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = cmd_wr ? WR : RA;
         WR:      if (w_aw_done && w_w_done) w_next = WB;
         WB:      if (m_axi_bvalid) w_next = DONE;
         RA:      if (m_axi_arready) w_next = RD;
         RD:      if (m_axi_rvalid) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= AXI_RESP_OKAY;
      end else begin
         if (w_accept) begin
            r_addr    <= cmd_addr;
            r_wdata   <= cmd_wdata;
            r_wstrb   <= cmd_wstrb;
            r_awvalid <= cmd_wr;
            r_wvalid  <= cmd_wr;
         end else begin
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs)  r_wvalid  <= 1'b0;
         end
         // Write completions report zero data so stale read data never leaks out.
         if (w_b_hs) begin
            r_rsp_rdata <= '0;
            r_rsp_resp  <= m_axi_bresp;
         end else if (w_r_hs) begin
            r_rsp_rdata <= m_axi_rdata;
            r_rsp_resp  <= m_axi_rresp;
         end
      end
   end

   assign cmd_ready     = (r_state == IDLE);
   assign rsp_valid     = (r_state == DONE);
   assign rsp_rdata     = r_rsp_rdata;
   assign rsp_resp      = r_rsp_resp;

   assign m_axi_awaddr  = r_addr;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = (r_state == WB);

   assign m_axi_araddr  = r_addr;
   assign m_axi_arvalid = (r_state == RA);
   assign m_axi_rready  = (r_state == RD);

endmodule

// File: tb/tb_axilite_master.sv
// tb/tb_axilite_master.sv - directed bench for axilite_master with a small AXI4-Lite memory slave
module tb_axilite_master;
   import axil_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_wr = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_axi_awaddr;
   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [1:0]  m_axi_bresp;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic [31:0] m_axi_araddr;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rvalid;
   logic        m_axi_rready;

   always #5 aclk = ~aclk;

   axilite_master dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready)
   );

   int n_vec = 0;
   int n_miss = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // memory slave: four words at 0x10000000, everything else reads 0x00000BAD
   logic [31:0] mem [0:3];
   int          aw_delay = 0;
   bit          early_b = 1'b0;
   bit          r_hold = 1'b0;
   logic [1:0]  force_resp = AXI_RESP_OKAY;
   int          aw_cnt;
   bit          aw_got, w_got, b_issued;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;

   assign m_axi_awready = (aw_cnt >= aw_delay);
   assign m_axi_wready  = 1'b1;
   assign m_axi_arready = 1'b1;

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         aw_cnt       <= 0;
         aw_got       <= 1'b0;
         w_got        <= 1'b0;
         b_issued     <= 1'b0;
         m_axi_bvalid <= 1'b0;
         m_axi_bresp  <= 2'b00;
         m_axi_rvalid <= 1'b0;
         m_axi_rresp  <= 2'b00;
         m_axi_rdata  <= '0;
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin : slv
         bit          ag, wg;
         logic [31:0] a, d;
         logic [3:0]  s;
         ag = aw_got; a = aw_addr_q;
         wg = w_got;  d = w_data_q; s = w_strb_q;
         if (m_axi_awvalid && m_axi_awready) begin
            ag = 1'b1; a = m_axi_awaddr; aw_cnt <= 0;
         end else if (m_axi_awvalid) begin
            aw_cnt <= aw_cnt + 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            wg = 1'b1; d = m_axi_wdata; s = m_axi_wstrb;
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (ag && wg) begin
            if (a[31:4] == 28'h1000000)
               for (int i = 0; i < 4; i++)
                  if (s[i]) mem[a[3:2]][8*i +: 8] <= d[8*i +: 8];
            ag = 1'b0; wg = 1'b0;
            if (!b_issued) begin
               m_axi_bvalid <= 1'b1; m_axi_bresp <= force_resp;
            end
            b_issued <= 1'b0;
         end else if (early_b && wg && !b_issued) begin
            m_axi_bvalid <= 1'b1; m_axi_bresp <= force_resp; b_issued <= 1'b1;
         end
         aw_got <= ag; aw_addr_q <= a;
         w_got  <= wg; w_data_q  <= d; w_strb_q <= s;
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
         if (m_axi_arvalid && m_axi_arready && !r_hold) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rresp  <= force_resp;
            m_axi_rdata  <= (m_axi_araddr[31:4] == 28'h1000000) ? mem[m_axi_araddr[3:2]] : 32'h00000BAD;
         end
      end
   end

   // monitors
   int          cyc = 0;
   int          acc_cnt = 0;
   int          aw_cyc = 0;
   int          w_cyc = 0;
   int          viol = 0;
   bit          p_aw, p_w, p_ar;
   logic [31:0] rsp_data_q [$];
   logic [1:0]  rsp_resp_q [$];
   int          rsp_cyc_q  [$];

   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
   end

   always @(negedge aclk) begin
      if (rsp_valid) begin
         rsp_data_q.push_back(rsp_rdata);
         rsp_resp_q.push_back(rsp_resp);
         rsp_cyc_q.push_back(cyc);
      end
      if (m_axi_awvalid) aw_cyc++;
      if (m_axi_wvalid)  w_cyc++;
      if (m_axi_bready && (m_axi_awvalid || m_axi_wvalid)) viol++;
      if (aresetn && ((p_aw && !m_axi_awvalid) || (p_w && !m_axi_wvalid) || (p_ar && !m_axi_arvalid))) viol++;
      p_aw = aresetn && m_axi_awvalid && !m_axi_awready;
      p_w  = aresetn && m_axi_wvalid && !m_axi_wready;
      p_ar = aresetn && m_axi_arvalid && !m_axi_arready;
   end

   task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int acc_edge);
      int n = 0;
      @(negedge aclk);
      cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb; cmd_valid = 1'b1;
      while (!cmd_ready && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 100) check_val("accept timeout", n, 0);
      acc_edge = cyc + 1;
      @(negedge aclk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input string tag);
      int n = 0;
      while (rsp_data_q.size() < target && n < 100) begin
         @(negedge aclk);
         n++;
      end
      if (n >= 100) check_val({tag, " response timeout"}, rsp_data_q.size(), target);
   endtask

   task automatic xact(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input logic [31:0] exp_d, input logic [1:0] exp_r, input int exp_lat);
      int base, acc;
      base = rsp_data_q.size();
      issue(wr, addr, data, strb, acc);
      wait_rsp(base + 1, tag);
      repeat (3) @(negedge aclk);
      check_val({tag, " rsp count"}, rsp_data_q.size() - base, 1);
      if (rsp_data_q.size() > base) begin
         check_val({tag, " rdata"}, rsp_data_q[base], exp_d);
         check_val({tag, " resp"}, rsp_resp_q[base], exp_r);
         if (exp_lat > 0) check_val({tag, " latency"}, rsp_cyc_q[base] + 1 - acc, exp_lat);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b_a [3];
      logic [31:0] b2b_d [3];
      int          base, a0, w0, v0, n, acc;

      b2b_a[0] = 32'h10000004; b2b_d[0] = 32'hDEADCAFE;
      b2b_a[1] = 32'h10000010; b2b_d[1] = 32'h00000BAD;
      b2b_a[2] = 32'h10000008; b2b_d[2] = 32'h12345678;

      repeat (3) @(negedge aclk);
      check_val("reset awvalid", m_axi_awvalid, 0);
      check_val("reset wvalid", m_axi_wvalid, 0);
      check_val("reset arvalid", m_axi_arvalid, 0);
      check_val("reset bready/rready", {m_axi_bready, m_axi_rready}, 0);
      check_val("reset rsp_valid", rsp_valid, 0);
      check_val("reset addr", m_axi_awaddr, 0);
      check_val("reset wdata/wstrb", {m_axi_wdata, m_axi_wstrb}, 0);
      check_val("reset rsp regs", {rsp_rdata, rsp_resp}, 0);
      aresetn = 1'b1;
      @(negedge aclk);
      check_val("cmd_ready after reset", cmd_ready, 1);

      xact("wr full", 1'b1, 32'h10000004, 32'hDEADBEEF, 4'hF, 32'h0, AXI_RESP_OKAY, 3);
      xact("rd full", 1'b0, 32'h10000004, 32'h0, 4'h0, 32'hDEADBEEF, AXI_RESP_OKAY, 3);
      xact("wr strb3", 1'b1, 32'h10000004, 32'h0000CAFE, 4'h3, 32'h0, AXI_RESP_OKAY, 3);
      xact("rd merged", 1'b0, 32'h10000004, 32'h0, 4'h0, 32'hDEADCAFE, AXI_RESP_OKAY, 3);
      xact("rd unmapped", 1'b0, 32'h10000010, 32'h0, 4'h0, 32'h00000BAD, AXI_RESP_OKAY, 3);

      force_resp = AXI_RESP_SLVERR;
      xact("wr slverr", 1'b1, 32'h1000000C, 32'h11112222, 4'hF, 32'h0, AXI_RESP_SLVERR, 3);
      force_resp = AXI_RESP_DECERR;
      xact("rd decerr", 1'b0, 32'h1000000C, 32'h0, 4'h0, 32'h11112222, AXI_RESP_DECERR, 3);
      force_resp = AXI_RESP_OKAY;

      // slow AW, immediate W, B offered before AW has been taken
      aw_delay = 5; early_b = 1'b1;
      a0 = aw_cyc; w0 = w_cyc; v0 = viol;
      xact("wr slow aw", 1'b1, 32'h10000008, 32'h12345678, 4'hF, 32'h0, AXI_RESP_OKAY, 8);
      check_val("slow aw awvalid cycles", aw_cyc - a0, 6);
      check_val("slow aw wvalid cycles", w_cyc - w0, 1);
      check_val("slow aw protocol", viol - v0, 0);
      aw_delay = 0; early_b = 1'b0;

      // three reads with cmd_valid held high throughout
      base = rsp_data_q.size();
      a0 = acc_cnt;
      @(negedge aclk);
      cmd_wr = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_addr = b2b_a[i];
         n = 0;
         while (!cmd_ready && n < 100) begin
            @(negedge aclk);
            n++;
         end
         @(negedge aclk);
      end
      cmd_valid = 1'b0;
      wait_rsp(base + 3, "b2b");
      repeat (4) @(negedge aclk);
      check_val("b2b accepts", acc_cnt - a0, 3);
      check_val("b2b rsp count", rsp_data_q.size() - base, 3);
      for (int i = 0; i < 3; i++)
         if (rsp_data_q.size() > base + i)
            check_val($sformatf("b2b rdata %0d", i), rsp_data_q[base + i], b2b_d[i]);

      // reset while waiting for read data
      r_hold = 1'b1;
      base = rsp_data_q.size();
      issue(1'b0, 32'h10000004, 32'h0, 4'h0, acc);
      n = 0;
      while (!m_axi_rready && n < 20) begin
         @(negedge aclk);
         n++;
      end
      check_val("stalled in RD", m_axi_rready, 1);
      #2 aresetn = 1'b0;
      #1;
      check_val("mid reset arvalid", m_axi_arvalid, 0);
      check_val("mid reset rready", m_axi_rready, 0);
      check_val("mid reset rsp_valid", rsp_valid, 0);
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      r_hold = 1'b0;
      repeat (2) @(negedge aclk);
      check_val("no rsp across reset", rsp_data_q.size() - base, 0);
      check_val("cmd_ready after mid reset", cmd_ready, 1);
      xact("wr after reset", 1'b1, 32'h10000000, 32'hA5A5A5A5, 4'hF, 32'h0, AXI_RESP_OKAY, 3);
      xact("rd after reset", 1'b0, 32'h10000000, 32'h0, 4'h0, 32'hA5A5A5A5, AXI_RESP_OKAY, 3);
      check_val("protocol violations", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
